// File: rtl/sdiv_arb.sv
// sdiv_arb: several requesters share one pipelined signed divider.
// A round-robin arbiter issues at most one divide per cycle. A tag pipe
// carries {vld,id,dz} next to the divider. Results are written to a response FIFO.
// FIFO space is reserved with credits when an op issues, because the divider cannot stall.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both high.
// req_ready is a one-hot grant and is computed from req_valid. A requester must
// hold valid, and must not gate valid on ready. rsp_valid comes from FIFO
// occupancy. The consumer pops the head with rsp_ready.

// sdiv_raw: restoring signed divider, one quotient bit per stage, WIDTH stages.
// It has no stall and no reset. The result lines up WIDTH cycles after the operands.
module sdiv_raw #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] st_rem [WIDTH];
  logic [WIDTH-1:0] st_acc [WIDTH];
  logic [WIDTH-1:0] st_dvs [WIDTH-1];
  logic [WIDTH-1:0] st_nq, st_nr;

  assign sa    = dividend[WIDTH-1];
  assign sb    = divisor[WIDTH-1];
  assign mag_a = sa ? -dividend : dividend;
  assign mag_b = sb ? -divisor  : divisor;

  // One restoring step: shift the next dividend bit into the partial remainder.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] nacc;
    trial = {rem, acc[WIDTH-1]};
    nacc  = {acc[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, dvs}) begin
      trial   = trial - {1'b0, dvs};
      nacc[0] = 1'b1;
    end
    return {trial[WIDTH-1:0], nacc};
  endfunction

  // Pipeline datapath: stage s retires quotient bit WIDTH-1-s.
  always_ff @(posedge clk) begin
    {st_rem[0], st_acc[0]} <= div_step('0, mag_a, mag_b);
    st_dvs[0] <= mag_b;
    st_nq[0]  <= sa ^ sb;
    st_nr[0]  <= sa;
    for (int s = 1; s < WIDTH; s++) begin
      {st_rem[s], st_acc[s]} <= div_step(st_rem[s-1], st_acc[s-1], st_dvs[s-1]);
      st_nq[s] <= st_nq[s-1];
      st_nr[s] <= st_nr[s-1];
    end
    for (int s = 1; s < WIDTH - 1; s++) st_dvs[s] <= st_dvs[s-1];
  end

  // The magnitude of most-negative / -1 is 2^(W-1), which wraps back to most-negative.
  assign quotient  = st_nq[WIDTH-1] ? -st_acc[WIDTH-1] : st_acc[WIDTH-1];
  assign remainder = st_nr[WIDTH-1] ? -st_rem[WIDTH-1] : st_rem[WIDTH-1];
endmodule

module sdiv_arb #(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 32,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_dz,
  output logic                  busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = IDW + 2 * WIDTH + 1;

  logic [IDW-1:0]   ptr, grant_idx;
  logic [CW-1:0]    outstanding, count;
  logic             can_issue, found, accept, pop, wr;
  logic [NREQ-1:0]  grant_oh;
  logic [WIDTH-1:0] op_dividend, op_divisor, div_q, div_r;
  logic [WIDTH-1:0] tag_vld, tag_dz;
  logic [IDW-1:0]   tag_id [WIDTH];
  logic [RW-1:0]    mem [DEPTH];
  logic [RW-1:0]    wr_data;
  logic [PW-1:0]    wr_ptr, rd_ptr;

  assign can_issue = outstanding < CW'(DEPTH);

  // Round-robin search from ptr; grant only with a free credit and out of reset.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found     = 1'b1;
        grant_idx = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    if (found && can_issue && !reset) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready = grant_oh;
  assign accept    = |grant_oh;
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = outstanding != '0;

  // Operand mux: the granted slice in the accept cycle, zero when idle.
  always_comb begin
    op_dividend = '0;
    op_divisor  = '0;
    if (accept) begin
      op_dividend = req_dividend[int'(grant_idx) * WIDTH +: WIDTH];
      op_divisor  = req_divisor[int'(grant_idx) * WIDTH +: WIDTH];
    end
  end

  // Arbiter pointer and credit counter. A pop frees a credit only for the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      outstanding <= '0;
    end else begin
      if (accept) ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      outstanding <= outstanding + CW'(accept) - CW'(pop);
    end
  end

  sdiv_raw #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .dividend  (op_dividend),
    .divisor   (op_divisor),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Tag valid bits are reset, so a reset drops every op that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_vld <= '0;
    else       tag_vld <= {tag_vld[WIDTH-2:0], accept};
  end

  // Tag payload moves alongside the divider stages.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_idx;
    tag_dz[0] <= op_divisor == '0;
    for (int s = 1; s < WIDTH; s++) begin
      tag_id[s] <= tag_id[s-1];
      tag_dz[s] <= tag_dz[s-1];
    end
  end

  assign wr      = tag_vld[WIDTH-1];
  assign wr_data = tag_dz[WIDTH-1] ? {tag_id[WIDTH-1], {2*WIDTH{1'b0}}, 1'b1}
                                   : {tag_id[WIDTH-1], div_q, div_r, 1'b0};

  // FIFO storage; the head is read straight from the array.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers wrap modulo DEPTH. count is the FIFO occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  assign rsp_valid = count != '0;
  assign {rsp_id, rsp_quotient, rsp_remainder, rsp_dz} = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                  !(wr && count == CW'(DEPTH)));
endmodule
